// File: rtl/sids_window_fetch.sv
// Vertical window fetcher: gathers NUM_ROWS SRAM words, one per image row, into one wide word.
// A one-row-down step reuses the rows already held and fetches only the new bottom row.
module sids_window_fetch #(
  parameter int NUM_ROWS   = 3,
  parameter int WORD_BYTES = 4,
  parameter int PIX_ADDR_W = 20,
  parameter int REUSE_EN   = 1
) (
  input  logic                                clk,
  input  logic                                n_rst,
  input  logic [31:0]                         image_width,
  input  logic                                fill_buff,
  input  logic [PIX_ADDR_W-1:0]               ED_rpixNum,
  input  logic                                SI_dfb,
  input  logic [WORD_BYTES*8-1:0]             SI_rdata,
  output logic [1:0]                          SI_mode,
  output logic [PIX_ADDR_W-1:0]               SI_rpixNum,
  output logic                                buff_filled,
  output logic [NUM_ROWS*WORD_BYTES*8-1:0]    ED_rdata
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam int IDX_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [IDX_W-1:0]      LAST_ROW  = IDX_W'(NUM_ROWS - 1);
  localparam logic [PIX_ADDR_W-1:0] BOTTOM_OFS = PIX_ADDR_W'(NUM_ROWS - 1);
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_READ = 2'b01;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        row_idx;
  logic [PIX_ADDR_W-1:0]   base;
  logic [PIX_ADDR_W-1:0]   iw;
  logic [PIX_ADDR_W-1:0]   prev_base;
  logic                    win_valid;
  logic [WORD_W-1:0]       rows [NUM_ROWS];

  logic [PIX_ADDR_W-1:0]   iw_in;
  logic                    reuse_hit;
  logic [PIX_ADDR_W-1:0]   reuse_addr;

  function automatic logic [PIX_ADDR_W-1:0] addr_add(input logic [PIX_ADDR_W-1:0] a,
                                                     input logic [PIX_ADDR_W-1:0] b);
    return a + b;
  endfunction

  if (PIX_ADDR_W < 32) begin : g_iw_trunc
    logic unused_iw_hi;
    assign iw_in        = image_width[PIX_ADDR_W-1:0];
    assign unused_iw_hi = ^image_width[31:PIX_ADDR_W];
  end else begin : g_iw_ext
    assign iw_in = PIX_ADDR_W'(image_width);
  end

  // A hit means the request sits exactly one image row below the last completed window.
  assign reuse_hit  = (REUSE_EN != 0) && (NUM_ROWS > 1) && win_valid &&
                      (ED_rpixNum == addr_add(prev_base, iw_in));
  assign reuse_addr = addr_add(ED_rpixNum, BOTTOM_OFS * iw_in);

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_out
    assign ED_rdata[r*WORD_W +: WORD_W] = rows[r];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= S_IDLE;
      SI_mode     <= MODE_IDLE;
      SI_rpixNum  <= '0;
      buff_filled <= 1'b0;
      win_valid   <= 1'b0;
      row_idx     <= '0;
      base        <= '0;
      iw          <= '0;
      prev_base   <= '0;
      for (int r = 0; r < NUM_ROWS; r++) rows[r] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fill_buff) begin
            base        <= ED_rpixNum;
            iw          <= iw_in;
            buff_filled <= 1'b0;
            SI_mode     <= MODE_READ;
            state       <= S_FETCH;
            if (reuse_hit) begin
              for (int r = 0; r < NUM_ROWS - 1; r++) rows[r] <= rows[r+1];
              row_idx    <= LAST_ROW;
              SI_rpixNum <= reuse_addr;
            end else begin
              row_idx    <= '0;
              SI_rpixNum <= ED_rpixNum;
            end
          end
        end
        S_FETCH: begin
          if (SI_dfb) begin
            rows[row_idx] <= SI_rdata;
            if (row_idx == LAST_ROW) begin
              state       <= S_IDLE;
              SI_mode     <= MODE_IDLE;
              buff_filled <= 1'b1;
              win_valid   <= 1'b1;
              prev_base   <= base;
            end else begin
              // Running accumulator steps the read address down one image row.
              row_idx    <= row_idx + IDX_W'(1);
              SI_rpixNum <= addr_add(SI_rpixNum, iw);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sids_window_fetch.sv
// Scoreboard bench for sids_window_fetch: one reuse-enabled and one reuse-disabled instance,
// with a bench-side SRAM responder checking every read address against a queue of expectations.
module tb_sids_window_fetch;

  logic        tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic        n_rst;
  logic [31:0] image_width;
  logic        fill_buff;
  logic [19:0] ED_rpixNum;
  logic        SI_dfb  = 1'b0;
  logic [31:0] SI_rdata = '0;
  logic        sel;

  logic        fill0, fill1, dfb0, dfb1;
  logic [1:0]  mode0, mode1, mode_m;
  logic [19:0] rpix0, rpix1, rpix_m;
  logic        bf0, bf1, bf_m;
  logic [95:0] ed0, ed1, ed_m;

  assign fill0  = fill_buff & ~sel;
  assign fill1  = fill_buff &  sel;
  assign dfb0   = SI_dfb & ~sel;
  assign dfb1   = SI_dfb &  sel;
  assign mode_m = sel ? mode1 : mode0;
  assign rpix_m = sel ? rpix1 : rpix0;
  assign bf_m   = sel ? bf1   : bf0;
  assign ed_m   = sel ? ed1   : ed0;

  sids_window_fetch #(.NUM_ROWS(3), .WORD_BYTES(4), .PIX_ADDR_W(20), .REUSE_EN(1)) dut_reuse (
    .clk(tb_clk), .n_rst(n_rst), .image_width(image_width), .fill_buff(fill0),
    .ED_rpixNum(ED_rpixNum), .SI_dfb(dfb0), .SI_rdata(SI_rdata), .SI_mode(mode0),
    .SI_rpixNum(rpix0), .buff_filled(bf0), .ED_rdata(ed0)
  );

  sids_window_fetch #(.NUM_ROWS(3), .WORD_BYTES(4), .PIX_ADDR_W(20), .REUSE_EN(0)) dut_noreuse (
    .clk(tb_clk), .n_rst(n_rst), .image_width(image_width), .fill_buff(fill1),
    .ED_rpixNum(ED_rpixNum), .SI_dfb(dfb1), .SI_rdata(SI_rdata), .SI_mode(mode1),
    .SI_rpixNum(rpix1), .buff_filled(bf1), .ED_rdata(ed1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          rd_cnt   = 0;
  int          stall_left  = 0;
  int          stall_after = 1;
  bit          idle_dfb = 1'b0;
  logic [19:0] exp_addr_q [$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [19:0] a);
    logic [7:0] p;
    p = a[7:0];
    return {p + 8'd3, p + 8'd2, p + 8'd1, p};
  endfunction

  function automatic logic [95:0] win_model(input logic [19:0] b, input logic [31:0] w);
    logic [19:0] a1, a2;
    a1 = b + w[19:0];
    a2 = a1 + w[19:0];
    return {mem_word(a2), mem_word(a1), mem_word(b)};
  endfunction

  // SRAM responder: answers one cycle after a read is presented, optionally stalling.
  always @(negedge tb_clk) begin
    SI_dfb = 1'b0;
    if (mode_m == 2'b01) begin
      if (stall_left > 0 && rd_cnt == stall_after) begin
        stall_left--;
        if (exp_addr_q.size() > 0) chk("stall_hold", 96'(rpix_m), 96'(exp_addr_q[0]));
      end else begin
        SI_dfb   = 1'b1;
        SI_rdata = mem_word(rpix_m);
        rd_cnt++;
        if (exp_addr_q.size() > 0) chk("rd_addr", 96'(rpix_m), 96'(exp_addr_q.pop_front()));
      end
    end else if (idle_dfb) begin
      SI_dfb   = 1'b1;
      SI_rdata = $urandom;
    end
  end

  task automatic req(input logic [19:0] b, input logic [31:0] w, input int first_row,
                     input logic [95:0] win, input int stall, input bit pulse);
    int cyc;
    for (int r = first_row; r < 3; r++) exp_addr_q.push_back(b + 20'(r) * w[19:0]);
    rd_cnt      = 0;
    stall_left  = stall;
    ED_rpixNum  = b;
    image_width = w;
    fill_buff   = 1'b1;
    @(negedge tb_clk);
    chk("accept_mode", 96'(mode_m), 96'(2'b01));
    chk("accept_filled", 96'(bf_m), 96'(0));
    cyc = 0;
    while (!bf_m && cyc < 200) begin
      fill_buff = pulse && (cyc == 1);
      @(negedge tb_clk);
      cyc++;
    end
    fill_buff = 1'b0;
    chk("latency", 96'(cyc), 96'(3 - first_row + stall));
    chk("done_mode", 96'(mode_m), 96'(2'b00));
    chk("read_count", 96'(rd_cnt), 96'(3 - first_row));
    chk("window", ed_m, win);
  endtask

  task automatic idle_check(input int n, input logic [95:0] win);
    int c0;
    c0 = rd_cnt;
    idle_dfb = 1'b1;
    repeat (n) @(negedge tb_clk);
    idle_dfb = 1'b0;
    chk("idle_mode", 96'(mode_m), 96'(2'b00));
    chk("idle_filled", 96'(bf_m), 96'(1));
    chk("idle_window", ed_m, win);
    chk("idle_reads", 96'(rd_cnt), 96'(c0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_rst       = 1'b0;
    fill_buff   = 1'b0;
    image_width = '0;
    ED_rpixNum  = '0;
    sel         = 1'b0;
    repeat (2) @(negedge tb_clk);
    chk("rst_mode", 96'(mode_m), 96'(0));
    chk("rst_rpix", 96'(rpix_m), 96'(0));
    chk("rst_filled", 96'(bf_m), 96'(0));
    chk("rst_window", ed_m, 96'(0));
    n_rst = 1'b1;
    @(negedge tb_clk);

    req(20'd0, 32'd8, 0, 96'h13121110_0B0A0908_03020100, 0, 1'b0);
    req(20'd8, 32'd8, 2, 96'h1B1A1918_13121110_0B0A0908, 0, 1'b0);
    req(20'd9, 32'd8, 0, win_model(20'd9, 32'd8), 0, 1'b0);

    stall_after = 1;
    req(20'd0, 32'd8, 0, 96'h13121110_0B0A0908_03020100, 5, 1'b1);
    idle_check(4, 96'h13121110_0B0A0908_03020100);

    req(20'hFFFFC, 32'd8, 0, {mem_word(20'h0000C), mem_word(20'h00004), mem_word(20'hFFFFC)}, 0, 1'b0);

    req(20'd100, 32'd8, 0, win_model(20'd100, 32'd8), 0, 1'b0);
    exp_addr_q.push_back(20'd200);
    exp_addr_q.push_back(20'd208);
    rd_cnt      = 0;
    ED_rpixNum  = 20'd200;
    image_width = 32'd8;
    fill_buff   = 1'b1;
    @(posedge tb_clk);
    #1 fill_buff = 1'b0;
    @(posedge tb_clk);
    @(posedge tb_clk);
    #1;
    chk("pre_rst_mode", 96'(mode_m), 96'(2'b01));
    n_rst = 1'b0;
    #1;
    chk("async_rst_mode", 96'(mode_m), 96'(0));
    chk("async_rst_rpix", 96'(rpix_m), 96'(0));
    chk("async_rst_filled", 96'(bf_m), 96'(0));
    chk("async_rst_window", ed_m, 96'(0));
    exp_addr_q.delete();
    @(negedge tb_clk);
    n_rst = 1'b1;
    @(negedge tb_clk);
    req(20'd108, 32'd8, 0, win_model(20'd108, 32'd8), 0, 1'b0);

    sel = 1'b1;
    @(negedge tb_clk);
    req(20'd0, 32'd8, 0, 96'h13121110_0B0A0908_03020100, 0, 1'b0);
    req(20'd8, 32'd8, 0, 96'h1B1A1918_13121110_0B0A0908, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sids_window_fetch.md
# sids_window_fetch

Parametrised successor to the sample image data storage buffer. On request from the edge-detection engine it fetches a vertical stack of `NUM_ROWS` SRAM words and presents them as one wide window word. The stack starts at a given pixel number, with one word per image row. When the engine steps down by exactly one image row, the block reuses the rows it already holds and fetches only the new bottom row. It sits between the edge-detection datapath and the SRAM read arbiter, in place of the fixed 3×32-bit buffer.

## Interface
- `NUM_ROWS`, 3: number of image rows in the window (≥1).
- `WORD_BYTES`, 4: bytes (pixels) per SRAM read word.
- `PIX_ADDR_W`, 20: width of pixel-number addresses.
- `REUSE_EN`, 1: enables row-shift reuse on a one-row-down step.
- `clk`  in  1  system clock, all state on rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `image_width`  in  32  pixels per image row; low `PIX_ADDR_W` bits used; sampled at request acceptance.
- `fill_buff`  in  1  request a window fill (level; accepted only when idle).
- `ED_rpixNum`  in  PIX_ADDR_W  pixel number of window top-left; sampled at acceptance.
- `SI_dfb`  in  1  SRAM data-from-bus valid for the current read.
- `SI_rdata`  in  WORD_BYTES*8  SRAM read word; byte 0 (bits 7:0) is the pixel at `SI_rpixNum`.
- `SI_mode`  out  2  2'b01 = read request active; 2'b00 = idle.
- `SI_rpixNum`  out  PIX_ADDR_W  pixel number of the current read.
- `buff_filled`  out  1  window complete and `ED_rdata` valid.
- `ED_rdata`  out  NUM_ROWS*WORD_BYTES*8  window; row r at bits [r*W*8 +: W*8], where W = `WORD_BYTES` and row 0 is the top row.

## Operation
- States: IDLE, FETCH.
- IDLE, `fill_buff`=1 at an edge: accept.
  - Latch `base`=`ED_rpixNum` and `iw`=`image_width`.
  - Deassert `buff_filled`. Enter FETCH.
- Reuse hit: `REUSE_EN`=1, `NUM_ROWS`>1, `win_valid`=1, and `ED_rpixNum` == (`prev_base` + `image_width`) mod 2^PIX_ADDR_W.
  - On hit, at the accept edge, row r ← row r+1 for r=0..NUM_ROWS-2.
  - Start row index = NUM_ROWS-1.
  - Otherwise start row index = 0 (full fetch).
- FETCH:
  - `SI_mode`=01.
  - `SI_rpixNum` = (base + row_idx*iw) mod 2^PIX_ADDR_W, held constant until `SI_dfb`.
- Edge with `SI_dfb`=1 in FETCH:
  - row[row_idx] ← `SI_rdata`.
  - If row_idx = NUM_ROWS-1: go to IDLE, `buff_filled`←1, `win_valid`←1, `prev_base`←base.
  - Otherwise row_idx+1; `SI_mode` stays 01 without a gap.
- `fill_buff` during FETCH: ignored (not queued).
- `SI_dfb` during IDLE: ignored, no storage change.
- `buff_filled` stays 1 until the next accepted request; `ED_rdata` is stable while it is 1.
- `ED_rdata` is not guaranteed coherent while `buff_filled`=0.
- A change of `image_width` mid-fetch has no effect; `iw` is latched.
- Address arithmetic is unsigned and wraps modulo 2^PIX_ADDR_W. The row multiply uses a running accumulator (addr += iw per row), not a multiplier.

## Timing
- Reset values: `SI_mode`=00, `SI_rpixNum`=0, `buff_filled`=0, `ED_rdata`=0; internally `win_valid`=0, state IDLE.
- Reset asserted mid-FETCH: immediate return to reset values. The next request is always a full fetch.
- Accept at edge E0: `SI_mode`=01 and a valid `SI_rpixNum` after E0.
- Full fetch, `SI_dfb` held 1: rows captured at E1..E(NUM_ROWS); `buff_filled`=1 after E(NUM_ROWS), `SI_mode`=00 after that same edge.
- Reuse fetch, `SI_dfb` held 1: capture and `buff_filled`=1 after E1.
- Each `SI_dfb`=0 cycle in FETCH adds one cycle of latency; there is no timeout.
- New request earliest: `fill_buff` high in the cycle after `buff_filled` rises. It is accepted at the next edge, and `buff_filled` falls after that edge.

## Test plan
- Full fill: NUM_ROWS=3, image_width=8, ED_rpixNum=0, SRAM model returns word {p+3,p+2,p+1,p} (bytes in ascending address order) with `SI_dfb` 1 cycle after each request.
  - Required `SI_rpixNum` sequence: 0, 8, 16.
  - Required `ED_rdata` = {0x13121110, 0x0B0A0908, 0x03020100}.
  - `buff_filled`=1 with `SI_mode`=00.
- Reuse: after the full fill, request ED_rpixNum=8.
  - Exactly one read, at 24.
  - `ED_rdata` = {0x1B1A1918, 0x13121110, 0x0B0A0908}.
- No reuse: request ED_rpixNum=9 (not a +image_width step), then REUSE_EN=0 with a +8 step.
  - Both produce three reads: 9, 17, 25 for the first case.
- Stalls and ignores:
  - `SI_dfb` low for 5 cycles on row 1: `SI_rpixNum` held at 8 throughout.
  - `fill_buff` pulsed mid-fetch: no extra fetch.
  - `SI_dfb` in IDLE: `ED_rdata` unchanged.
- Wrap: PIX_ADDR_W=20, ED_rpixNum=0xFFFFC, image_width=8.
  - Reads at 0xFFFFC, 0x00004, 0x0000C.
- Reset mid-fetch: assert `n_rst`=0 after row 1 capture.
  - All outputs at reset values asynchronously.
  - The following +image_width request performs a full 3-row fetch.
